// File: rtl/wb_spi_master.sv
// wb_spi_master: Wishbone slave SPI master, one 8-bit full-duplex transfer per DATA write,
// programmable SCLK divider, all CPOL/CPHA modes, MSB/LSB-first, software chip selects.
module wb_spi_master #(
  parameter int NUM_CS      = 1,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [2:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic              irq_o,
  output logic              spi_sclk_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic [NUM_CS-1:0] spi_cs_n_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, dcnt_q, dcnt_d;
  logic [3:0] ecnt_q, ecnt_d, ctrl_q, ctrl_d;
  logic [NUM_CS-1:0] cs_q, cs_d;
  logic [7:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d, rx_in, tx_sh, ld_sh;
  logic done_q, done_d, ovr_q, ovr_d, irq_q, irq_d, ack_q, ack_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d;
  logic [31:0] dat_q, dat_d, rdata;
  logic req, wr, rd, run, tick, odd, last, sample, shift, lsb, cpha, tx_bit, ld_bit, unused_ok;

  assign req       = wb_cyc_i & wb_stb_i;
  assign wr        = ack_q & req & wb_we_i & wb_sel_i[0];
  assign rd        = ack_q & req & ~wb_we_i;
  assign run       = state_q == RUN;
  assign lsb       = ctrl_q[2];
  assign cpha      = ctrl_q[1];
  assign tick      = run && dcnt_q == div_q;
  assign odd       = ~ecnt_q[0];
  assign last      = tick && ecnt_q == 4'd15;
  // CPHA=0 samples on odd edges, CPHA=1 on even; the 16th edge never shifts in CPHA=0
  assign sample    = tick && (odd ^ cpha);
  assign shift     = tick && (cpha ? odd : !odd && !last);
  assign rx_in     = lsb ? {spi_miso_i, rx_sh_q[7:1]} : {rx_sh_q[6:0], spi_miso_i};
  assign tx_bit    = lsb ? tx_q[0] : tx_q[7];
  assign tx_sh     = lsb ? tx_q >> 1 : tx_q << 1;
  assign ld_bit    = lsb ? wb_dat_i[0] : wb_dat_i[7];
  assign ld_sh     = lsb ? wb_dat_i[7:0] >> 1 : wb_dat_i[7:0] << 1;
  assign unused_ok = ^{wb_sel_i[3:1], wb_dat_i};

  assign rdata = wb_adr_i == 3'd0 ? {24'd0, rx_q} :
                 wb_adr_i == 3'd1 ? {29'd0, ovr_q, done_q, run} :
                 wb_adr_i == 3'd2 ? {28'd0, ctrl_q} :
                 wb_adr_i == 3'd3 ? 32'(div_q) :
                 wb_adr_i == 3'd4 ? 32'(cs_q) : 32'd0;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    ecnt_d  = ecnt_q;
    ctrl_d  = ctrl_q;
    div_d   = div_q;
    cs_d    = cs_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    done_d  = done_q;
    ovr_d   = ovr_q;
    mosi_d  = mosi_q;
    sclk_d  = run ? sclk_q ^ tick : ctrl_q[0];
    ack_d   = req & ~ack_q;
    dat_d   = ack_d ? rdata : 32'd0;
    irq_d   = ctrl_q[3] & done_q;
    if (run) begin
      dcnt_d = tick ? '0 : dcnt_q + DIV_WIDTH'(1);
      ecnt_d = ecnt_q + 4'(tick);
    end
    if (sample) rx_sh_d = rx_in;
    if (shift) begin
      mosi_d = tx_bit;
      tx_d   = tx_sh;
    end
    if (wr && wb_adr_i == 3'd0 && run) ovr_d = 1'b1;
    if (wr && wb_adr_i == 3'd0 && !run) begin
      state_d = RUN;
      tx_d    = cpha ? wb_dat_i[7:0] : ld_sh;
      mosi_d  = cpha ? mosi_q : ld_bit;
    end
    if (wr && wb_adr_i == 3'd1) begin
      done_d = done_q & ~wb_dat_i[1];
      ovr_d  = ovr_q & ~wb_dat_i[2];
    end
    if (wr && wb_adr_i == 3'd2 && !run) ctrl_d = wb_dat_i[3:0];
    if (wr && wb_adr_i == 3'd3 && !run) div_d = wb_dat_i[DIV_WIDTH-1:0];
    if (wr && wb_adr_i == 3'd4) cs_d = wb_dat_i[NUM_CS-1:0];
    if (rd && wb_adr_i == 3'd0) done_d = 1'b0;
    // completion is applied last so it beats a same-cycle DONE clear
    if (last) begin
      state_d = IDLE;
      rx_d    = sample ? rx_in : rx_sh_q;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      ecnt_q  <= '0;
      ctrl_q  <= '0;
      div_q   <= DIV_WIDTH'(DEFAULT_DIV);
      cs_q    <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      ecnt_q  <= ecnt_d;
      ctrl_q  <= ctrl_d;
      div_q   <= div_d;
      cs_q    <= cs_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      irq_q   <= irq_d;
      ack_q   <= ack_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      dat_q   <= dat_d;
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_q;
  assign irq_o      = irq_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_n_o = ~cs_q;
endmodule

// File: tb/tb_wb_spi_master.sv
// tb_wb_spi_master: scoreboard bench; an SPI slave model checks MOSI bytes and supplies MISO,
// expected MOSI/RX bytes are queued at transfer start and popped when the DUT produces them.
module tb_wb_spi_master;
  logic clk = 0, rst = 1;
  logic [2:0] adr = 0;
  logic [31:0] dat_i = 0, dat_o;
  logic [3:0] sel = 0, cs_n;
  logic we = 0, cyc = 0, stb = 0, ack, irq, sclk, mosi, miso, sl_miso = 0, loop = 0;
  logic m_cpol = 0, m_cpha = 0, m_lsb = 0, prev_sclk = 0;
  logic [7:0] sl_byte = 0, sl_rx = 0;
  logic [7:0] exp_mosi[$], exp_rx[$];
  int checks = 0, errors = 0, cyc_n = 0, sl_edges = 0, sl_bits = 0, c0 = 0;
  int edge_cyc [0:16];

  wb_spi_master #(.NUM_CS(4), .DIV_WIDTH(16), .DEFAULT_DIV(0)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack),
    .irq_o(irq), .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(miso), .spi_cs_n_o(cs_n)
  );

  assign miso = loop ? mosi : sl_miso;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // slave model: counts SCLK edges, captures MOSI and advances MISO on the master's sampling edges
  always @(posedge clk) begin
    #1;
    if (!rst && sclk !== prev_sclk) begin
      sl_edges++;
      if (sl_edges <= 16) edge_cyc[sl_edges] = cyc_n;
      if (sl_edges[0] != m_cpha && sl_bits < 8) begin
        sl_rx[m_lsb ? sl_bits : 7 - sl_bits] = mosi;
        sl_bits++;
        if (sl_bits == 8) begin
          chk("mosi_sb_size", 32'(exp_mosi.size()), 32'd1);
          if (exp_mosi.size() != 0) chk("mosi_byte", 32'(sl_rx), 32'(exp_mosi.pop_front()));
        end else sl_miso = sl_byte[m_lsb ? sl_bits : 7 - sl_bits];
      end
    end
    prev_sclk = sclk;
  end

  task automatic wb_acc(input logic w, input logic [2:0] a, input logic [31:0] wd, output logic [31:0] rd);
    int n = 0;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; dat_i = wd; sel = 4'hf;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    chk("ack", 32'(ack), 32'd1);
    rd = dat_o;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0; sel = 0;
  endtask

  task automatic wb_wr(input logic [2:0] a, input logic [31:0] wd);
    logic [31:0] x;
    wb_acc(1'b1, a, wd, x);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_acc(1'b0, a, 32'd0, r);
    chk(tag, r, exp);
  endtask

  task automatic rd_data_sb();
    logic [31:0] r;
    wb_acc(1'b0, 3'd0, 32'd0, r);
    chk("rx_sb_size", 32'(exp_rx.size()), 32'd1);
    if (exp_rx.size() != 0) chk("rx_data", r, {24'd0, exp_rx.pop_front()});
  endtask

  task automatic sl_clear();
    sl_edges = 0;
    sl_bits = 0;
    sl_rx = 0;
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] sb, input logic [7:0] rx);
    repeat (2) @(posedge clk);
    #1;
    sl_clear();
    sl_byte = sb;
    sl_miso = sb[m_lsb ? 0 : 7];
    exp_mosi.push_back(tx);
    exp_rx.push_back(rx);
    wb_wr(3'd0, {24'd0, tx});
    c0 = cyc_n;
  endtask

  task automatic wait_xfer(input int div, input bit irq_chk);
    int n = 0;
    while (sl_edges < 16 && n < 40 * (div + 1)) begin @(negedge clk); n++; end
    chk("edge_count", 32'(sl_edges), 32'd16);
    if (irq_chk) begin
      chk("irq_before", 32'(irq), 32'd0);
      @(negedge clk);
      chk("irq_rise", 32'(irq), 32'd1);
    end
    chk("first_edge", 32'(edge_cyc[1] - c0), 32'(div + 1));
    chk("half_period", 32'(edge_cyc[2] - edge_cyc[1]), 32'(div + 1));
    chk("busy_len", 32'(edge_cyc[16] - c0), 32'(16 * (div + 1)));
    chk("sclk_idle", 32'(sclk), 32'(m_cpol));
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'hf);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat_o", dat_o, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rd_chk("rst_status", 3'd1, 32'd0);
    rd_chk("rst_ctrl", 3'd2, 32'd0);
    rd_chk("rst_div", 3'd3, 32'd0);
    rd_chk("rst_cs", 3'd4, 32'd0);
    rd_chk("rst_data", 3'd0, 32'd0);
    wb_wr(3'd5, 32'hffff_ffff);
    rd_chk("reg5", 3'd5, 32'd0);
    rd_chk("reg5_status", 3'd1, 32'd0);

    loop = 1;
    start_xfer(8'hA5, 8'h00, 8'hA5);
    rd_chk("m0_busy", 3'd1, 32'h1);
    wait_xfer(0, 1'b0);
    rd_chk("m0_done", 3'd1, 32'h2);
    rd_data_sb();
    rd_chk("m0_done_clr", 3'd1, 32'h0);
    chk("m0_pulses", 32'(sl_edges), 32'd16);
    loop = 0;

    m_cpol = 1; m_cpha = 1; m_lsb = 1;
    wb_wr(3'd2, 32'h7);
    wb_wr(3'd3, 32'h3);
    chk("m3_sclk_idle", 32'(sclk), 32'd1);
    start_xfer(8'h96, 8'h3C, 8'h3C);
    wait_xfer(3, 1'b0);
    rd_chk("m3_done", 3'd1, 32'h2);
    rd_data_sb();

    m_cpol = 0; m_cpha = 0; m_lsb = 0;
    wb_wr(3'd2, 32'h0);
    wb_wr(3'd3, 32'h1);
    start_xfer(8'h5A, 8'hC3, 8'hC3);
    rd_chk("ovr_busy", 3'd1, 32'h1);
    wb_wr(3'd0, 32'hff);
    wb_wr(3'd2, 32'hf);
    wb_wr(3'd3, 32'h7);
    rd_chk("ovr_ctrl_kept", 3'd2, 32'h0);
    rd_chk("ovr_div_kept", 3'd3, 32'h1);
    rd_chk("ovr_flag", 3'd1, 32'h5);
    wait_xfer(1, 1'b0);
    rd_chk("ovr_done", 3'd1, 32'h6);
    wb_wr(3'd1, 32'h4);
    rd_chk("ovr_w1c", 3'd1, 32'h2);
    rd_data_sb();
    rd_chk("ovr_clr_all", 3'd1, 32'h0);

    wb_wr(3'd2, 32'h8);
    wb_wr(3'd3, 32'h0);
    start_xfer(8'h42, 8'h81, 8'h81);
    wait_xfer(0, 1'b1);
    wb_wr(3'd1, 32'h2);
    chk("irq_hold", 32'(irq), 32'd1);
    @(posedge clk); #1;
    chk("irq_fall", 32'(irq), 32'd0);
    rd_data_sb();

    m_cpol = 1;
    wb_wr(3'd4, 32'ha);
    chk("cs_n", 32'(cs_n), 32'h5);
    wb_wr(3'd2, 32'h9);
    wb_wr(3'd3, 32'h3);
    repeat (2) @(posedge clk);
    #1 sl_clear();
    wb_wr(3'd0, 32'hff);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_sclk", 32'(sclk), 32'd1);
    chk("mid_mosi", 32'(mosi), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    chk("mrst_sclk", 32'(sclk), 32'd0);
    chk("mrst_mosi", 32'(mosi), 32'd0);
    chk("mrst_cs_n", 32'(cs_n), 32'hf);
    chk("mrst_ack", 32'(ack), 32'd0);
    chk("mrst_dat_o", dat_o, 32'd0);
    chk("mrst_irq", 32'(irq), 32'd0);
    rst = 0;
    rd_chk("mrst_status", 3'd1, 32'd0);
    rd_chk("mrst_ctrl", 3'd2, 32'd0);
    rd_chk("mrst_div", 3'd3, 32'd0);
    rd_chk("mrst_cs", 3'd4, 32'd0);
    rd_chk("mrst_data", 3'd0, 32'd0);
    chk("sb_empty", 32'(exp_mosi.size() + exp_rx.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
